led_sequencer: RTL and testbench

Parametrised LED pattern sequencer for the iCEblink40 LED bank. It divides the board clock into a slow step tick and, on each tick, advances one of four selectable patterns across `N_LEDS` outputs: rotate up, rotate down, bounce, or binary count. It also emits step and wrap strobes and supports pausing and mode changes at run time. It sits directly between the board clock and the LED pins, or feeds other status logic through the strobes.

---
 rtl/led_sequencer_if.sv | 27 ++
 rtl/led_sequencer.sv | 120 ++++++++++++
 tb/tb_led_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_sequencer_if.sv
// Control and LED-drive bundle for led_sequencer.
// The master drives mode/run; the slave returns the LED pattern and strobes.
interface led_sequencer_if #(
    parameter int N_LEDS = 4
);
    logic [1:0]        mode;
    logic              run;
    logic [N_LEDS-1:0] led;
    logic              step;
    logic              wrap;

    modport master (
        output mode,
        output run,
        input  led,
        input  step,
        input  wrap
    );

    modport slave (
        input  mode,
        input  run,
        output led,
        output step,
        output wrap
    );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: prescaled step tick advancing rotate/bounce/count
// patterns, with registered step and wrap strobes.
module led_sequencer #(
    parameter int N_LEDS    = 4,
    parameter int LOG2DELAY = 16
) (
    input logic            clk,
    input logic            rst,
    led_sequencer_if.slave bus
);
    localparam int PW = $clog2(N_LEDS);

    typedef enum logic [1:0] {
        M_UP     = 2'b00,
        M_DOWN   = 2'b01,
        M_BOUNCE = 2'b10,
        M_BIN    = 2'b11
    } mode_t;

    localparam logic [PW-1:0]        LAST    = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]        POS_ONE = PW'(1);
    localparam logic [N_LEDS-1:0]    HOT0    = N_LEDS'(1);
    localparam logic [N_LEDS-1:0]    CNT_ONE = N_LEDS'(1);
    localparam logic [LOG2DELAY-1:0] PRE_ONE = LOG2DELAY'(1);

    logic [LOG2DELAY-1:0] pre_q, pre_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic [N_LEDS-1:0]    cnt_q, cnt_d;
    mode_t                amode_q, amode_d;
    logic [N_LEDS-1:0]    led_q, led_d;
    logic                 step_q, step_d;
    logic                 wrap_q, wrap_d;

    mode_t                req;
    logic                 tick;
    logic [PW-1:0]        nxt;

    assign req  = mode_t'(bus.mode);
    assign tick = bus.run && (pre_q == '1);

    always_comb begin
        pre_d   = bus.run ? pre_q + PRE_ONE : pre_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        amode_d = amode_q;
        led_d   = led_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        nxt     = '0;
        if (tick) begin
            step_d = 1'b1;
            if (req != amode_q) begin
                // A new mode restarts its pattern; no advance on this tick.
                amode_d = req;
                pos_d   = '0;
                dir_d   = 1'b0;
                cnt_d   = '0;
                led_d   = (req == M_BIN) ? '0 : HOT0;
            end else begin
                unique case (amode_q)
                    M_UP: begin
                        pos_d  = (pos_q == LAST) ? '0 : pos_q + POS_ONE;
                        wrap_d = (pos_q == LAST);
                        led_d  = HOT0 << pos_d;
                    end
                    M_DOWN: begin
                        pos_d  = (pos_q == '0) ? LAST : pos_q - POS_ONE;
                        wrap_d = (pos_q == '0);
                        led_d  = HOT0 << pos_d;
                    end
                    M_BOUNCE: begin
                        nxt   = dir_q ? pos_q - POS_ONE : pos_q + POS_ONE;
                        pos_d = nxt;
                        if (nxt == LAST) begin
                            dir_d = 1'b1;
                        end
                        if (nxt == '0) begin
                            dir_d  = 1'b0;
                            wrap_d = 1'b1;
                        end
                        led_d = HOT0 << nxt;
                    end
                    M_BIN: begin
                        cnt_d  = cnt_q + CNT_ONE;
                        wrap_d = (cnt_q == '1);
                        led_d  = cnt_d;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            amode_q <= M_UP;
            led_q   <= HOT0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            amode_q <= amode_d;
            led_q   <= led_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (N_LEDS=4, LOG2DELAY=2) against
// a pattern model indexed by tick count since the last restart.
module tb_led_sequencer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    led_sequencer_if #(.N_LEDS(4)) bus ();

    led_sequencer #(
        .N_LEDS(4),
        .LOG2DELAY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: running-edge count, applied mode, tick index in pattern.
    int         m_runs;
    int         m_idx;
    logic [1:0] m_amode;
    logic [3:0] m_led;
    logic       m_step;
    logic       m_wrap;

    task automatic model_reset();
        m_runs  = 0;
        m_idx   = 0;
        m_amode = 2'b00;
        m_led   = 4'b0001;
        m_step  = 1'b0;
        m_wrap  = 1'b0;
    endtask

    task automatic model_edge();
        int p;
        int ph;
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (bus.run) begin
            m_runs++;
            if (m_runs % 4 == 0) begin
                m_step = 1'b1;
                if (bus.mode != m_amode) begin
                    m_amode = bus.mode;
                    m_idx   = 0;
                    m_led   = (bus.mode == 2'b11) ? 4'b0000 : 4'b0001;
                end else begin
                    m_idx++;
                    case (m_amode)
                        2'b00: begin
                            p      = m_idx % 4;
                            m_led  = 4'b0001 << p;
                            m_wrap = (p == 0);
                        end
                        2'b01: begin
                            p      = (4 - m_idx % 4) % 4;
                            m_led  = 4'b0001 << p;
                            m_wrap = (m_idx % 4 == 1);
                        end
                        2'b10: begin
                            ph     = m_idx % 6;
                            p      = (ph < 4) ? ph : 6 - ph;
                            m_led  = 4'b0001 << p;
                            m_wrap = (ph == 0);
                        end
                        default: begin
                            m_led  = 4'(m_idx % 16);
                            m_wrap = (m_idx % 16 == 0);
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bus.run  = 1'b1;
        bus.mode = 2'b00;
        model_reset();
        repeat (3) begin
            tick_clk();
            model_reset();
            checks++;
            if (bus.led !== 4'b0001 || bus.step !== 1'b0 || bus.wrap !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold led=%b step=%b wrap=%b want 0001 0 0",
                         bus.led, bus.step, bus.wrap);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_rotate_up();
        int steps;
        int wraps;
        steps = 0;
        wraps = 0;
        do_reset();
        bus.mode = 2'b00;
        bus.run  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick_clk();
            steps += int'(bus.step);
            wraps += int'(bus.wrap);
            checks++;
            if ({bus.led, bus.step, bus.wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL rot_up c=%0d got %b %b %b want %b %b %b",
                         c, bus.led, bus.step, bus.wrap, m_led, m_step, m_wrap);
            end
            if (c == 4) begin
                checks++;
                if (bus.led !== 4'b0010 || bus.step !== 1'b1) begin
                    errors++;
                    $display("FAIL rot_up_first led=%b step=%b want 0010 1",
                             bus.led, bus.step);
                end
            end
        end
        checks++;
        if (steps != 4 || wraps != 1) begin
            errors++;
            $display("FAIL rot_up_counts steps=%0d wraps=%0d want 4 1", steps, wraps);
        end
    endtask

    task automatic test_rotate_down();
        do_reset();
        bus.mode = 2'b01;
        bus.run  = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick_clk();
            checks++;
            if ({bus.led, bus.step, bus.wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL rot_down c=%0d got %b %b %b want %b %b %b",
                         c, bus.led, bus.step, bus.wrap, m_led, m_step, m_wrap);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        bus.mode = 2'b10;
        bus.run  = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            tick_clk();
            checks++;
            if ({bus.led, bus.step, bus.wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL bounce c=%0d got %b %b %b want %b %b %b",
                         c, bus.led, bus.step, bus.wrap, m_led, m_step, m_wrap);
            end
        end
    endtask

    task automatic test_binary();
        do_reset();
        bus.mode = 2'b11;
        bus.run  = 1'b1;
        for (int c = 1; c <= 74; c++) begin
            tick_clk();
            if (c == 70) bus.mode = 2'b00;
            checks++;
            if ({bus.led, bus.step, bus.wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL binary c=%0d got %b %b %b want %b %b %b",
                         c, bus.led, bus.step, bus.wrap, m_led, m_step, m_wrap);
            end
        end
        checks++;
        if (bus.led !== 4'b0001 || bus.step !== 1'b0) begin
            errors++;
            $display("FAIL bin_to_up led=%b step=%b want 0001 0", bus.led, bus.step);
        end
    endtask

    task automatic test_pause();
        int first;
        first = 0;
        do_reset();
        bus.mode = 2'b00;
        bus.run  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick_clk();
            if (bus.step === 1'b1 && first == 0) first = c;
            bus.run = !(c >= 2 && c < 9);
            checks++;
            if ({bus.led, bus.step, bus.wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL pause c=%0d got %b %b %b want %b %b %b",
                         c, bus.led, bus.step, bus.wrap, m_led, m_step, m_wrap);
            end
        end
        checks++;
        if (first != 11) begin
            errors++;
            $display("FAIL pause_delay first_step=%0d want 11", first);
        end
    endtask

    task automatic test_async_reset();
        int n;
        int first;
        n     = 0;
        first = 0;
        do_reset();
        bus.mode = 2'b10;
        bus.run  = 1'b1;
        while (!(m_amode == 2'b10 && m_idx == 4 && m_step) && n < 100) begin
            tick_clk();
            n++;
        end
        checks++;
        if (n >= 100 || bus.led !== 4'b0100) begin
            errors++;
            $display("FAIL arst_setup led=%b n=%0d want 0100", bus.led, n);
        end
        #3 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.led !== 4'b0001 || bus.step !== 1'b0 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL arst_now led=%b step=%b wrap=%b want 0001 0 0",
                     bus.led, bus.step, bus.wrap);
        end
        bus.mode = 2'b00;
        #2 rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick_clk();
            if (bus.step === 1'b1 && first == 0) first = c;
            checks++;
            if ({bus.led, bus.step, bus.wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL arst_seq c=%0d got %b %b %b want %b %b %b",
                         c, bus.led, bus.step, bus.wrap, m_led, m_step, m_wrap);
            end
        end
        checks++;
        if (first != 4) begin
            errors++;
            $display("FAIL arst_first first_step=%0d want 4", first);
        end
    endtask

    task automatic test_random();
        do_reset();
        bus.mode = 2'($urandom_range(0, 3));
        bus.run  = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            tick_clk();
            checks++;
            if ({bus.led, bus.step, bus.wrap} !== {m_led, m_step, m_wrap}) begin
                errors++;
                $display("FAIL random c=%0d got %b %b %b want %b %b %b",
                         c, bus.led, bus.step, bus.wrap, m_led, m_step, m_wrap);
            end
            bus.run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        bus.run  = 1'b0;
        bus.mode = 2'b00;
        test_reset();
        test_rotate_up();
        test_rotate_down();
        test_bounce();
        test_binary();
        test_pause();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
